// File: rtl/match_stim_gen_pkg.sv
// match_pkg: shared state encoding, defaults and LFSR step for the match stimulus generator
// Contents: state_t enum, default PATTERN/SEED/BASE/COUNT/PAT_ADDR/RES_ADDR/TIMEOUT,
//           lfsr_next() advancing the 8-bit LFSR (taps b7^b5^b4^b3 into bit0).
package match_pkg;
    typedef enum logic [2:0] {IDLE, WR_PAT, FILL, RELEASE, WAIT, READ, CHECK, FIN} state_t;
    localparam logic [3:0] PATTERN_DEF = 4'b1101;
    localparam logic [7:0] SEED_DEF    = 8'hA5;
    localparam int         BASE_DEF    = 32;
    localparam int         COUNT_DEF   = 64;
    localparam int         PAT_ADDR_DEF = 6;
    localparam int         RES_ADDR_DEF = 7;
    localparam int         TIMEOUT_DEF = 4096;
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction
endpackage

// File: rtl/match_stim_gen_if.sv
// match_stim_gen_if: memory/matcher/status bundle between the stimulus generator and its environment
// master (generator): drives wr_en, wr_addr, wr_data, rd_addr, dut_init, exp_ct, cyc_ct,
//                     done, pass, fail, timeout; samples rd_data, dut_done.
// slave (memory + matcher side): the mirror image.
interface match_stim_gen_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        dut_init;
    logic        dut_done;
    logic [7:0]  exp_ct;
    logic [15:0] cyc_ct;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, dut_init, exp_ct, cyc_ct, done, pass, fail, timeout,
        input  rd_data, dut_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, dut_init, exp_ct, cyc_ct, done, pass, fail, timeout,
        output rd_data, dut_done
    );
endinterface

// File: rtl/match_stim_gen_nib_match.sv
// nib_match: combinational test of one byte against PATTERN over its five 4-bit windows
// Ports: data (in, 8) byte under test; hit (out, 1) high when any window equals PATTERN.
module nib_match
    import match_pkg::*;
#(
    parameter logic [3:0] PATTERN = PATTERN_DEF
) (
    input  logic [7:0] data,
    output logic       hit
);
    // several overlapping windows may match; the OR makes the byte count once
    assign hit = (data[3:0] == PATTERN) | (data[4:1] == PATTERN) | (data[5:2] == PATTERN) |
                 (data[6:3] == PATTERN) | (data[7:4] == PATTERN);
endmodule

// File: rtl/match_stim_gen.sv
// match_stim_gen: fills a data memory with LFSR bytes, runs a nibble matcher and checks its count
// Ports: clk (in) rising-edge clock; init (in) sync active-high reset, release starts a run;
//        bus (match_stim_gen_if.master) memory write/read, matcher control, result status.
// Build option: MATCH_STIM_TIMEOUT_EN enables the WAIT watchdog (TIMEOUT_CYC); otherwise timeout is 0.
module match_stim_gen
    import match_pkg::*;
#(
    parameter logic [3:0] PATTERN     = PATTERN_DEF,
    parameter logic [7:0] SEED        = SEED_DEF,
    parameter int         BASE        = BASE_DEF,
    parameter int         COUNT       = COUNT_DEF,
    parameter int         PAT_ADDR    = PAT_ADDR_DEF,
    parameter int         RES_ADDR    = RES_ADDR_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic init,
    match_stim_gen_if.master bus
);
`ifdef MATCH_STIM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // an all-zero seed would lock the LFSR at zero
    localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0]  BASE8    = 8'(BASE);
    localparam logic [7:0]  PAT8     = 8'(PAT_ADDR);
    localparam logic [7:0]  RES8     = 8'(RES_ADDR);
    localparam logic [15:0] LAST     = 16'(COUNT - 1);
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT_CYC);

    state_t      state, state_nx;
    logic [7:0]  lfsr;
    logic [15:0] idx;
    logic        hit, to_hit, rd_eq;
    logic [7:0]  addr_nx;

    nib_match #(.PATTERN(PATTERN)) u_nib (.data(lfsr), .hit(hit));

    assign to_hit = TO_EN && (state == WAIT) && (bus.cyc_ct >= TO_LIM);
    assign rd_eq  = (bus.rd_data == bus.exp_ct);

    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            lfsr        <= SEED_EFF;
            idx         <= '0;
            bus.exp_ct  <= '0;
            bus.cyc_ct  <= '0;
            bus.pass    <= 1'b0;
            bus.fail    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == FILL) begin
                lfsr <= lfsr_next(lfsr);
                idx  <= idx + 16'd1;
                if (hit && bus.exp_ct != 8'hFF) bus.exp_ct <= bus.exp_ct + 8'd1;
            end
            if (state == WAIT && !to_hit && bus.cyc_ct != 16'hFFFF) bus.cyc_ct <= bus.cyc_ct + 16'd1;
            if (state == CHECK) begin
                bus.pass <= rd_eq;
                bus.fail <= !rd_eq;
            end
            if (to_hit) begin
                bus.timeout <= 1'b1;
                bus.fail    <= 1'b1;
                bus.pass    <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = WR_PAT;
            WR_PAT:  state_nx = FILL;
            FILL:    state_nx = (idx == LAST) ? RELEASE : FILL;
            RELEASE: state_nx = WAIT;
            WAIT:    state_nx = to_hit ? FIN : (bus.dut_done ? READ : WAIT);
            READ:    state_nx = CHECK;
            CHECK:   state_nx = FIN;
            default: state_nx = FIN;
        endcase
    end

    always_comb begin
        addr_nx     = (state == WR_PAT) ? PAT8 : (state == FILL) ? BASE8 + idx[7:0] : 8'h00;
        bus.wr_addr = addr_nx;
        bus.wr_data = (state == WR_PAT) ? {4'b0000, PATTERN} : (state == FILL) ? lfsr : 8'h00;
        // the result slot is never overwritten, even under an overlapping parameter set
        bus.wr_en    = (state == WR_PAT || state == FILL) && (addr_nx != RES8);
        bus.rd_addr  = RES8;
        bus.dut_init = (state == IDLE || state == WR_PAT || state == FILL);
        bus.done     = (state == FIN);
    end
endmodule

// File: tb/tb_match_stim_gen.sv
// tb_match_stim_gen: randomized scoreboard bench for match_stim_gen with a stub matcher
module tb_match_stim_gen;
    localparam int PAT = 13, BASE = 32, COUNT = 64, PAT_ADDR = 6, TO = 100;

    typedef struct {int addr; int data;} wr_t;
    typedef struct {int pass; int fail; int to; int ect; int cyc;} res_t;

    logic clk = 1'b0;
    logic init = 1'b1;
    always #5 clk = ~clk;

    match_stim_gen_if bus();
    match_stim_gen #(.SEED(8'h00), .TIMEOUT_CYC(TO)) dut (.clk(clk), .init(init), .bus(bus));

    logic [7:0] nm_in;
    logic       nm_hit;
    nib_match #(.PATTERN(4'b1101)) u_nm (.data(nm_in), .hit(nm_hit));

    wr_t  wq[$];
    res_t rq[$];
    int   n_pass = 0, n_tot = 0;
    int   delay = 10, err_off = 0, exp_model = 0, rel_cnt = 0;
    bit   never_done = 1'b0, early_noise = 1'b0;
    logic done_q = 1'b0;

    function automatic bit model_hit(input int b);
        for (int k = 0; k < 5; k++)
            if (((b >> k) & 15) == PAT) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // expected writes and final status of one complete run, from the byte-level rules
    task automatic plan_run();
        int v, cnt, nb;
        res_t r;
        v = 1;
        cnt = 0;
        wq.push_back('{PAT_ADDR, PAT});
        for (int i = 0; i < COUNT; i++) begin
            wq.push_back('{BASE + i, v});
            if (model_hit(v) && cnt < 255) cnt++;
            nb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
            v = ((v << 1) & 255) | nb;
        end
        exp_model = cnt;
        r.ect = cnt;
        if (never_done) begin
            r.pass = 0; r.fail = 1; r.to = 1; r.cyc = TO;
        end else begin
            r.pass = (err_off == 0); r.fail = (err_off != 0); r.to = 0; r.cyc = delay;
        end
        rq.push_back(r);
    endtask

    // stub matcher: result ready `delay` cycles after the release cycle
    always @(negedge clk) begin
        if (bus.dut_init) begin
            rel_cnt = 0;
            bus.dut_done = early_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            rel_cnt++;
            bus.dut_done = !never_done && (rel_cnt > delay);
        end
        bus.rd_data = 8'(exp_model + err_off);
    end

    always @(negedge clk) begin
        wr_t  w;
        res_t r;
        if (bus.wr_en) begin
            if (wq.size() == 0) chk("write_unexpected", int'(bus.wr_addr), -1);
            else begin
                w = wq.pop_front();
                chk("wr_addr", int'(bus.wr_addr), w.addr);
                chk("wr_data", int'(bus.wr_data), w.data);
            end
        end
        if (bus.done && !done_q) begin
            if (rq.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                r = rq.pop_front();
                chk("pass", int'(bus.pass), r.pass);
                chk("fail", int'(bus.fail), r.fail);
                chk("timeout", int'(bus.timeout), r.to);
                chk("exp_ct", int'(bus.exp_ct), r.ect);
                chk("cyc_ct", int'(bus.cyc_ct), r.cyc);
            end
        end
        done_q <= bus.done;
    end

    task automatic wait_done();
        for (int i = 0; i < 3000 && !bus.done; i++) @(negedge clk);
        if (!bus.done) chk("done_reached", 0, 1);
    endtask

    task automatic run_one(input int d, input int eo, input bit nd, input bit noise);
        delay = d;
        err_off = eo;
        never_done = nd;
        early_noise = noise;
        init = 1'b1;
        repeat (2) @(negedge clk);
        plan_run();
        init = 1'b0;
        wait_done();
    endtask

    initial begin
        int vec[4] = '{8'hD0, 8'h1A, 8'h00, 8'hDD};
        repeat (3) @(negedge clk);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_dut_init", int'(bus.dut_init), 1);
        chk("rst_exp_ct", int'(bus.exp_ct), 0);
        chk("rst_cyc_ct", int'(bus.cyc_ct), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_pass", int'(bus.pass), 0);
        chk("rst_fail", int'(bus.fail), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        for (int i = 0; i < 4; i++) begin
            nm_in = 8'(vec[i]);
            #1;
            chk("nib_match", int'(nm_hit), (i == 2) ? 0 : 1);
        end
        @(negedge clk);
        run_one(10, 0, 1'b0, 1'b0);
        run_one(10, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            run_one($urandom_range(1, 40), $urandom_range(0, 1) ? 0 : $urandom_range(1, 255),
                    1'b0, 1'($urandom_range(0, 1)));
        // abort a run partway through FILL, then rerun from scratch
        delay = 15; err_off = 0; never_done = 1'b0; early_noise = 1'b0;
        init = 1'b1;
        repeat (2) @(negedge clk);
        plan_run();
        init = 1'b0;
        for (int i = 0; i < 200 && !(bus.wr_en && bus.wr_addr == 8'(BASE + 20)); i++) @(negedge clk);
        chk("abort_point", int'(bus.wr_addr), BASE + 20);
        init = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", int'(bus.wr_en), 0);
        chk("abort_exp_ct", int'(bus.exp_ct), 0);
        chk("abort_dut_init", int'(bus.dut_init), 1);
        wq.delete();
        rq.delete();
        @(negedge clk);
        plan_run();
        init = 1'b0;
        wait_done();
`ifdef MATCH_STIM_TIMEOUT_EN
        run_one(5, 0, 1'b1, 1'b0);
`endif
        repeat (2) @(negedge clk);
        chk("writes_drained", wq.size(), 0);
        chk("results_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
